// File: rtl/jkff_mon_pkg.sv
// jkff_mon_pkg: monitor state encoding and the J-K next-state rule shared by the monitor files.
package jkff_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2,
        HALT  = 2'd3
    } state_t;

    function automatic logic jk_next(input logic j, input logic k, input logic q, input logic rst);
        return rst ? 1'b0 : (j && k) ? ~q : j ? 1'b1 : k ? 1'b0 : q;
    endfunction

endpackage

// File: rtl/jkff_monitor_ref.sv
// jk_ref_model: registered expectation of the flip-flop output at the next edge.
module jk_ref_model
    import jkff_mon_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  logic j,
    input  logic k,
    input  logic q,
    input  logic dut_rst,
    output logic exp_q,
    output logic exp_valid
);

    // Built from the sampled Q, so a single fault never propagates into later expectations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q     <= 1'b0;
            exp_valid <= 1'b0;
        end else if (clr) begin
            exp_q     <= 1'b0;
            exp_valid <= 1'b0;
        end else if (load) begin
            exp_q     <= jk_next(j, k, q, dut_rst);
            exp_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/jkff_monitor.sv
// jkff_monitor: checks a J-K flip-flop against a reference model and keeps
// sticky error status plus saturating comparison/mismatch statistics.
module jkff_monitor
    import jkff_mon_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Clear,
    input  logic             DutReset,
    input  logic             J,
    input  logic             K,
    input  logic             Q,
    output logic [1:0]       State,
    output logic             ExpQ,
    output logic             ExpValid,
    output logic             ErrPulse,
    output logic             Error,
    output logic [CNT_W-1:0] ChkCount,
    output logic [CNT_W-1:0] ErrCount,
    output logic [CNT_W-1:0] FirstErrAt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    logic   q_ok;
    logic   mismatch;
    logic   load;

    assign State = state;

    // An unknown Q fails the q_ok test and therefore lands on the mismatch side.
    always_comb begin
        q_ok     = ExpQ ? (Q == 1'b1) : (Q == 1'b0);
        mismatch = 1'b1;
        if (q_ok) mismatch = 1'b0;
        load = Enable && !Clear &&
               ((state == SYNC && DutReset) ||
                (state == CHECK && !(mismatch && STOP_ON_ERR != 0)));
    end

    jk_ref_model u_ref (
        .clk      (Clk),
        .rst_n    (Reset),
        .clr      (!load),
        .load     (load),
        .j        (J),
        .k        (K),
        .q        (Q),
        .dut_rst  (DutReset),
        .exp_q    (ExpQ),
        .exp_valid(ExpValid)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            ErrPulse   <= 1'b0;
            Error      <= 1'b0;
            ChkCount   <= '0;
            ErrCount   <= '0;
            FirstErrAt <= '0;
        end else begin
            ErrPulse <= 1'b0;
            if (Clear) begin
                state      <= IDLE;
                Error      <= 1'b0;
                ChkCount   <= '0;
                ErrCount   <= '0;
                FirstErrAt <= '0;
            end else if (!Enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: state <= SYNC;
                    SYNC: if (DutReset) state <= CHECK;
                    CHECK: begin
                        if (ExpValid) begin
                            ChkCount <= (ChkCount == CNT_MAX) ? ChkCount : ChkCount + 1'b1;
                            if (mismatch) begin
                                ErrPulse <= 1'b1;
                                Error    <= 1'b1;
                                ErrCount <= (ErrCount == CNT_MAX) ? ErrCount : ErrCount + 1'b1;
                                if (!Error) FirstErrAt <= ChkCount;
                                if (STOP_ON_ERR != 0) state <= HALT;
                            end
                        end
                    end
                    default: state <= HALT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jkff_monitor.sv
// tb_jkff_monitor: three monitor configurations watch one flip-flop stand-in;
// a bench model tracks each and literal checks pin the key scenarios.
module tb_jkff_monitor;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic Enable = 1'b0;
    logic Clear = 1'b0;
    logic DutReset = 1'b0;
    logic J = 1'b0;
    logic K = 1'b0;
    logic q_ff = 1'b0;
    logic fault = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [1:0]  st0, st1, st2;
    logic        eq0, eq1, eq2, ev0, ev1, ev2, ep0, ep1, ep2, er0, er1, er2;
    logic [15:0] cc0, ec0, fe0, cc1, ec1, fe1;
    logic [3:0]  cc2, ec2, fe2;

    always #5 Clk = ~Clk;

    // Flip-flop under observation; fault makes it ignore the toggle command.
    always @(posedge Clk)
        q_ff <= DutReset ? 1'b0 : (fault && J && K) ? q_ff :
                (J && K) ? !q_ff : J ? 1'b1 : K ? 1'b0 : q_ff;

    jkff_monitor #(.CNT_W(16), .STOP_ON_ERR(0)) u0 (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Clear(Clear), .DutReset(DutReset),
        .J(J), .K(K), .Q(q_ff), .State(st0), .ExpQ(eq0), .ExpValid(ev0), .ErrPulse(ep0),
        .Error(er0), .ChkCount(cc0), .ErrCount(ec0), .FirstErrAt(fe0));

    jkff_monitor #(.CNT_W(16), .STOP_ON_ERR(1)) u1 (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Clear(Clear), .DutReset(DutReset),
        .J(J), .K(K), .Q(q_ff), .State(st1), .ExpQ(eq1), .ExpValid(ev1), .ErrPulse(ep1),
        .Error(er1), .ChkCount(cc1), .ErrCount(ec1), .FirstErrAt(fe1));

    jkff_monitor #(.CNT_W(4), .STOP_ON_ERR(0)) u2 (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Clear(Clear), .DutReset(DutReset),
        .J(J), .K(K), .Q(q_ff), .State(st2), .ExpQ(eq2), .ExpValid(ev2), .ErrPulse(ep2),
        .Error(er2), .ChkCount(cc2), .ErrCount(ec2), .FirstErrAt(fe2));

    int m_st[3], m_cc[3], m_ec[3], m_fe[3];
    bit m_eq[3], m_ev[3], m_ep[3], m_er[3];
    int mx[3]  = '{65535, 65535, 15};
    bit stp[3] = '{1'b0, 1'b1, 1'b0};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int i);
        bit [3:0] tbl;
        bit ok;
        tbl = {!q_ff, 1'b1, 1'b0, q_ff};
        ok  = (q_ff === m_eq[i]);
        m_ep[i] = 1'b0;
        if (Clear) begin
            m_st[i] = 0; m_ev[i] = 0; m_eq[i] = 0; m_er[i] = 0;
            m_cc[i] = 0; m_ec[i] = 0; m_fe[i] = 0;
        end else if (!Enable) begin
            m_st[i] = 0; m_ev[i] = 0;
        end else if (m_st[i] == 0) begin
            m_st[i] = 1;
        end else if (m_st[i] == 1) begin
            if (DutReset) begin m_st[i] = 2; m_ev[i] = 1; m_eq[i] = 0; end
        end else if (m_st[i] == 2) begin
            if (!ok) begin
                m_ep[i] = 1;
                m_ec[i] = (m_ec[i] < mx[i]) ? m_ec[i] + 1 : mx[i];
                if (!m_er[i]) m_fe[i] = m_cc[i];
                m_er[i] = 1;
            end
            m_cc[i] = (m_cc[i] < mx[i]) ? m_cc[i] + 1 : mx[i];
            m_eq[i] = DutReset ? 1'b0 : tbl[{J, K}];
            if (!ok && stp[i]) begin m_st[i] = 3; m_ev[i] = 0; end
        end
    endtask

    always @(posedge Clk or negedge Reset) begin
        for (int i = 0; i < 3; i++) begin
            if (!Reset) begin
                m_st[i] = 0; m_ev[i] = 0; m_eq[i] = 0; m_ep[i] = 0; m_er[i] = 0;
                m_cc[i] = 0; m_ec[i] = 0; m_fe[i] = 0;
            end else begin
                step(i);
            end
        end
    end

    task automatic cmp(input int i, input int st, input bit eq, input bit ev, input bit ep,
                       input bit er, input int cc, input int ec, input int fe);
        chk($sformatf("u%0d.State", i), st, m_st[i]);
        chk($sformatf("u%0d.ExpValid", i), int'(ev), int'(m_ev[i]));
        if (m_ev[i]) chk($sformatf("u%0d.ExpQ", i), int'(eq), int'(m_eq[i]));
        chk($sformatf("u%0d.ErrPulse", i), int'(ep), int'(m_ep[i]));
        chk($sformatf("u%0d.Error", i), int'(er), int'(m_er[i]));
        chk($sformatf("u%0d.ChkCount", i), cc, m_cc[i]);
        chk($sformatf("u%0d.ErrCount", i), ec, m_ec[i]);
        chk($sformatf("u%0d.FirstErrAt", i), fe, m_fe[i]);
    endtask

    always @(negedge Clk) begin
        cmp(0, int'(st0), eq0, ev0, ep0, er0, int'(cc0), int'(ec0), int'(fe0));
        cmp(1, int'(st1), eq1, ev1, ep1, er1, int'(cc1), int'(ec1), int'(fe1));
        cmp(2, int'(st2), eq2, ev2, ep2, er2, int'(cc2), int'(ec2), int'(fe2));
    end

    task automatic cyc(input bit j, input bit k, input bit dr);
        J = j; K = k; DutReset = dr;
        @(posedge Clk);
        #1;
    endtask

    bit [1:0] jk_seq[5] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b11};
    bit       q_seq[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        chk("reset.State", int'(st0), 0);
        chk("reset.ExpQ", int'(eq0), 0);
        chk("reset.ChkCount", int'(cc0), 0);
        Reset = 1'b1;
        for (int i = 0; i < 20; i++) cyc(i[0], i[1], 1'b0);
        chk("idle.State", int'(st0), 0);
        chk("idle.ChkCount", int'(cc0), 0);
        chk("idle.Error", int'(er0), 0);
        Enable = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        for (int n = 0; n < 5; n++) begin
            cyc(jk_seq[n][1], jk_seq[n][0], 1'b0);
            chk($sformatf("seq.ExpQ[%0d]", n), int'(eq0), int'(q_seq[n]));
        end
        chk("seq.ChkCount", int'(cc0), 5);
        chk("seq.ErrCount", int'(ec0), 0);
        Clear = 1'b1;
        cyc(0, 0, 0);
        Clear = 1'b0;
        chk("clear.State", int'(st0), 0);
        chk("clear.ChkCount", int'(cc0), 0);
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        fault = 1'b1;
        cyc(1, 1, 0);
        fault = 1'b0;
        cyc(0, 0, 0);
        chk("fault.ErrPulse", int'(ep0), 1);
        cyc(0, 1, 0);
        chk("fault.ErrPulse_drop", int'(ep0), 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("fault.ErrCount", int'(ec0), 1);
        chk("fault.FirstErrAt", int'(fe0), 3);
        chk("fault.Error", int'(er0), 1);
        chk("halt.State", int'(st1), 3);
        chk("halt.ChkCount", int'(cc1), 4);
        Clear = 1'b1;
        cyc(0, 0, 0);
        Clear = 1'b0;
        chk("halt_clr.State", int'(st1), 0);
        chk("halt_clr.ChkCount", int'(cc1), 0);
        chk("halt_clr.ErrCount", int'(ec1), 0);
        chk("halt_clr.Error", int'(er1), 0);
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        for (int i = 0; i < 20; i++) cyc(i[0], i[1], 1'b0);
        chk("sat.ChkCount", int'(cc2), 15);
        chk("sat.Error", int'(er2), 0);
        chk("sat.wide_ChkCount", int'(cc0), 20);
        #2 Reset = 1'b0;
        #1;
        chk("async.State", int'(st0), 0);
        chk("async.ChkCount", int'(cc0), 0);
        chk("async.ExpValid", int'(ev0), 0);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        for (int i = 0; i < 4; i++) cyc(1, 0, 0);
        chk("resync.State", int'(st0), 1);
        chk("resync.ChkCount", int'(cc0), 0);
        cyc(0, 0, 1);
        cyc(1, 1, 0);
        cyc(0, 0, 0);
        chk("resync.ChkCount2", int'(cc0), 2);
        Enable = 1'b0;
        cyc(0, 0, 0);
        chk("disable.State", int'(st0), 0);
        chk("disable.ChkCount_kept", int'(cc0), 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
